// File: rtl/instr_loader_if.sv
// Byte-stream load channel for the instruction RAM.
// Source drives data/valid, the loader answers with ready.
interface instr_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/instr_loader.sv
// Loadable instruction RAM for scpu: combinational fetch port plus a
// framed byte loader (HDR, LEN, data, XOR checksum) that holds the CPU in reset.
module instr_loader #(
    parameter int          ADDR_W = 4,
    parameter int          DATA_W = 8,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    instr_loader_if.slave     load,
    output logic              cpu_rst,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        RUN,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   n;
    logic [7:0]        csum;

    logic accept;
    logic is_hdr;
    logic len_ok;
    logic last;

    assign instruction   = mem[pc];
    assign load.in_ready = (state != DONE);
    assign accept        = load.in_valid && load.in_ready;
    assign is_hdr        = (load.in_data == HDR);
    assign len_ok        = (load.in_data != 8'd0) &&
                           (32'(load.in_data) <= DEPTH);
    assign last          = (count == n - (ADDR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (accept && is_hdr) state_nx = LEN;
            end
            LEN: begin
                if (accept) state_nx = len_ok ? DATA : ERR;
            end
            DATA: begin
                if (accept && last) state_nx = CSUM;
            end
            CSUM: begin
                if (accept) state_nx = (load.in_data == csum) ? DONE : ERR;
            end
            DONE: begin
                state_nx = RUN;
            end
            ERR: begin
                if (accept && is_hdr) state_nx = LEN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // cpu_rst/busy track the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count        <= '0;
            n            <= '0;
            csum         <= '0;
            cpu_rst      <= 1'b0;
            busy         <= 1'b0;
            load_ok      <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            cpu_rst <= (state_nx != RUN);
            busy    <= (state_nx == LEN) || (state_nx == DATA) ||
                       (state_nx == CSUM) || (state_nx == DONE);
            if (accept) begin
                unique case (state)
                    RUN, ERR: begin
                        if (is_hdr) begin
                            load_ok  <= 1'b0;
                            load_err <= 1'b0;
                        end
                    end
                    LEN: begin
                        if (len_ok) begin
                            n     <= (ADDR_W+1)'(load.in_data);
                            count <= '0;
                            csum  <= '0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        mem[count[ADDR_W-1:0]] <= DATA_W'(load.in_data);
                        csum  <= csum ^ load.in_data;
                        count <= count + (ADDR_W+1)'(1);
                    end
                    CSUM: begin
                        if (load.in_data == csum) begin
                            load_ok      <= 1'b1;
                            words_loaded <= n;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: frame table plus reset-mid-frame
// and bubbled-stream sequences, checked against a small RAM model.
module tb_instr_loader;

    logic       clk;
    logic       rst;
    logic [3:0] pc;
    logic [7:0] instruction;
    logic       cpu_rst;
    logic       busy;
    logic       load_ok;
    logic       load_err;
    logic [4:0] words_loaded;

    instr_loader_if lif();

    instr_loader dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .instruction  (instruction),
        .load         (lif),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .load_ok      (load_ok),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           n;
        logic [159:0] p;
        bit           done;
        bit           ok;
        bit           err;
        int           words;
        bit           crst;
        bit           bub;
    } vec_t;

    int         nvec;
    int         nerr;
    logic [7:0] exp_mem [16];
    vec_t       tbl [10];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int n,
                                input logic [159:0] p, input bit done,
                                input bit ok, input bit err, input int words,
                                input bit crst, input bit bub);
        vec_t v;
        v.name  = nm;
        v.n     = n;
        v.p     = p;
        v.done  = done;
        v.ok    = ok;
        v.err   = err;
        v.words = words;
        v.crst  = crst;
        v.bub   = bub;
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input vec_t v, input int i);
        return v.p[(v.n-1-i)*8 +: 8];
    endfunction

    task automatic send(input logic [7:0] b, input bit bub, input string nm);
        bit r;
        int k;
        @(negedge clk);
        if (bub) begin
            lif.in_valid = 1'b0;
            lif.in_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        lif.in_valid = 1'b1;
        lif.in_data  = b;
        for (k = 0; k < 20; k++) begin
            r = lif.in_ready;
            @(posedge clk);
            if (r) break;
            @(negedge clk);
        end
        if (k == 20) begin
            nvec++;
            nerr++;
            $display("FAIL %s send_timeout: byte %0h not accepted", nm, b);
        end
        @(negedge clk);
        lif.in_valid = 1'b0;
        lif.in_data  = 8'($urandom);
    endtask

    task automatic model(input vec_t v);
        logic [7:0] len;
        if (v.n >= 2 && byte_at(v, 0) == 8'hA5) begin
            len = byte_at(v, 1);
            if (len >= 8'd1 && len <= 8'd16) begin
                for (int k = 0; k < int'(len) && 2 + k < v.n; k++)
                    exp_mem[k] = byte_at(v, 2 + k);
            end
        end
    endtask

    task automatic chk_mem(input string nm);
        for (int k = 0; k < 16; k++) begin
            pc = 4'(k);
            #1;
            chk($sformatf("%s mem[%0d]", nm, k), 32'(instruction),
                32'(exp_mem[k]));
        end
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            send(byte_at(v, i), v.bub, v.name);
            if (i == 0 && byte_at(v, 0) == 8'hA5) begin
                chk({v.name, " cpu_rst_after_hdr"}, 32'(cpu_rst), 32'd1);
                chk({v.name, " busy_after_hdr"}, 32'(busy), 32'd1);
            end
        end
        if (v.done) begin
            chk({v.name, " done_ready"}, 32'(lif.in_ready), 32'd0);
            chk({v.name, " done_cpu_rst"}, 32'(cpu_rst), 32'd1);
            @(negedge clk);
        end
        model(v);
        chk({v.name, " load_ok"}, 32'(load_ok), 32'(v.ok));
        chk({v.name, " load_err"}, 32'(load_err), 32'(v.err));
        chk({v.name, " words"}, 32'(words_loaded), 32'(v.words));
        chk({v.name, " cpu_rst"}, 32'(cpu_rst), 32'(v.crst));
        chk({v.name, " ready"}, 32'(lif.in_ready), 32'd1);
        chk_mem(v.name);
    endtask

    initial begin
        nvec         = 0;
        nerr         = 0;
        rst          = 1'b1;
        pc           = '0;
        lif.in_valid = 1'b0;
        lif.in_data  = '0;
        for (int k = 0; k < 16; k++) exp_mem[k] = 8'h00;

        tbl[0] = mk("good3", 6, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00},
                    1, 1, 0, 3, 0, 0);
        tbl[1] = mk("badcsum", 5, {8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00},
                    0, 0, 1, 3, 1, 0);
        tbl[2] = mk("recover", 4, {8'hA5, 8'h01, 8'h42, 8'h42},
                    1, 1, 0, 1, 0, 0);
        tbl[3] = mk("len0", 2, {8'hA5, 8'h00}, 0, 0, 1, 1, 1, 0);
        tbl[4] = mk("recover2", 4, {8'hA5, 8'h01, 8'h99, 8'h99},
                    1, 1, 0, 1, 0, 0);
        tbl[5] = mk("len17", 2, {8'hA5, 8'h11}, 0, 0, 1, 1, 1, 0);
        tbl[6] = mk("recover3", 4, {8'hA5, 8'h01, 8'h42, 8'h42},
                    1, 1, 0, 1, 0, 0);
        tbl[7] = mk("junk", 2, {8'h7E, 8'h55}, 0, 1, 0, 1, 0, 0);
        tbl[8] = mk("full16", 19,
                    {8'hA5, 8'h10, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                     8'h20, 8'h40, 8'h80, 8'hFF, 8'hFE, 8'hFD, 8'hFB,
                     8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h80},
                    1, 1, 0, 16, 0, 0);
        tbl[9] = mk("bubbles", 7,
                    {8'hA5, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08},
                    1, 1, 0, 4, 0, 1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset cpu_rst", 32'(cpu_rst), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset load_ok", 32'(load_ok), 32'd0);
        chk("reset load_err", 32'(load_err), 32'd0);
        chk("reset words", 32'(words_loaded), 32'd0);
        chk("reset ready", 32'(lif.in_ready), 32'd1);
        chk_mem("reset");

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

        pc = 4'd15;
        #1;
        chk("wrap pc15", 32'(instruction), 32'h0000_00BF);
        pc = pc + 4'd1;
        #1;
        chk("wrap pc0", 32'(instruction), 32'h0000_0001);

        send(8'hA5, 0, "rstmid");
        send(8'h04, 0, "rstmid");
        send(8'hAA, 0, "rstmid");
        send(8'hBB, 0, "rstmid");
        chk("rstmid busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) exp_mem[k] = 8'h00;
        chk("rstmid cpu_rst", 32'(cpu_rst), 32'd0);
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid load_ok", 32'(load_ok), 32'd0);
        chk("rstmid load_err", 32'(load_err), 32'd0);
        chk("rstmid words", 32'(words_loaded), 32'd0);
        chk("rstmid ready", 32'(lif.in_ready), 32'd1);
        chk_mem("rstmid");

        run_vec(tbl[9]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the scpu instruction-fetch interface: a 16x8 instruction RAM that replaces the fixed instruction ROM.
- Fetch side: combinational read of `mem[pc]`, same as the ROM.
- Load side: a framed byte stream with a valid/ready handshake fills the RAM.
- Holds the CPU in reset while a load is in progress and releases it cleanly afterwards.

Parameters:
- ADDR_W, 4, instruction address width; depth = 2**ADDR_W.
- DATA_W, 8, instruction width.
- HDR, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pc  in  ADDR_W  fetch address from pc
- instruction  out  DATA_W  `mem[pc]`, combinational
- in_data  in  8  load stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- cpu_rst  out  1  reset request to pc and register_file, OR'ed with rst at the top level
- busy  out  1  frame in progress
- load_ok  out  1  sticky: last frame completed with good checksum
- load_err  out  1  sticky: last frame aborted
- words_loaded  out  ADDR_W+1  data bytes written by the last successful frame

Behaviour:
- Accept means `in_valid && in_ready` sampled on a rising clk edge.
- Frame format:
  - HDR
  - LEN: 1..16
  - LEN data bytes: data byte k is written to `mem[k]`
  - CSUM: XOR of all data bytes
- States: RUN, LEN, DATA, CSUM, DONE, ERR.
- Reset (rst=1 at an edge), from any state:
  - state=RUN, all mem entries = 8'h00.
  - cpu_rst=0, busy=0, load_ok=0, load_err=0, words_loaded=0.
  - Internal count=0, xor=0.
  - Reset mid-frame discards the frame.
- in_ready = 1 in every state except DONE.
- RUN:
  - Accepted byte == HDR → LEN; clear load_ok and load_err.
  - Any other accepted byte is dropped; no state change.
- LEN:
  - Accepted byte in 1..16 → DATA; latch N, count=0, xor=0.
  - 0 or >16 → ERR.
- DATA:
  - Each accepted byte is written to `mem[count]` at that edge, then xor ^= byte and count++.
  - The accept with count == N-1 → CSUM.
  - Entries N..15 keep their previous contents.
- CSUM:
  - Accepted byte == xor → DONE; load_ok=1, words_loaded=N.
  - Mismatch → ERR.
- DONE: lasts exactly one cycle, then → RUN. in_ready=0 in DONE.
- ERR:
  - load_err=1; mem keeps any partially written bytes.
  - Accepted HDR → LEN (starts a new frame, clears load_err); other bytes are dropped.
- cpu_rst:
  - Registered output, 1 whenever the next state is LEN, DATA, CSUM, DONE or ERR.
  - Asserts the cycle after HDR is accepted.
  - Deasserts the cycle after DONE, so the first clk with cpu_rst=0 follows a CPU reset cycle and the CPU fetches `mem[0]` of the new image.
  - Stays high in ERR; the CPU never runs a corrupt image.
- busy = 1 in LEN, DATA, CSUM, DONE (registered like cpu_rst).
- Fetch path:
  - instruction reflects a write in the cycle after the write edge (write-first is not required).
  - The fetch path is unaffected by load activity apart from content changes.
- Bubbles: in_valid=0 cycles stall the FSM in its current state with no side effects.
- No timeout; an idle stream leaves the FSM parked.

Test Plan:
- After reset with no stream, pc=0..15 → instruction=8'h00; cpu_rst=0; in_ready=1.
- Stream A5,03,11,22,33,00 (XOR of 11^22^33=00):
  - mem[0..2]=11,22,33 and mem[3..15] unchanged.
  - load_ok=1, words_loaded=3.
  - cpu_rst high from the cycle after A5 through DONE+1, then low.
- Stream A5,02,0F,F0,00 (bad checksum; correct is FF):
  - load_err=1 and cpu_rst stays 1.
  - Then A5,01,42,42 → load_ok=1, load_err=0, mem[0]=42, cpu_rst drops.
- Stream A5,00 → ERR. Separately, A5,11 → ERR. In both cases mem is untouched.
- Stream 7E,55 in RUN → ignored, cpu_rst stays 0. Then a full 16-byte frame (16-byte XOR in CSUM) → all 16 entries updated, words_loaded=16, pc wrap 15→0 reads the new values.
- rst asserted mid-DATA after 2 of 4 bytes:
  - Next cycle: state RUN, mem all 00, flags 0, cpu_rst 0.
  - in_valid toggled randomly during a good frame → same final result as with no bubbles.
